// File: rtl/uart_alu_pkt_ctrl_if.sv
// Bundle of the receive-FIFO, transmit-FIFO and ALU signals around the packet controller.
//   master : the controller (pops RX, pushes TX, drives ALU operands, reports busy)
//   slave  : the environment (FIFOs and the combinational ALU)
// Signals:
//   i_rx_empty / i_r_data / o_rd_uart : RX FIFO empty flag, FWFT head byte, pop strobe
//   i_tx_full  / o_w_data / o_wr_uart : TX FIFO full flag, byte to send, push strobe
//   o_op_a / o_op_b / o_op_code       : registered ALU operands and opcode
//   i_result                          : combinational ALU result
//   o_busy                            : controller is not idle
interface uart_alu_pkt_ctrl_if #(
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned OPCODE_BITS = 6,
  parameter int unsigned OP_BYTES    = 2
);
  localparam int unsigned W = OP_BYTES * DATA_BITS;

  logic                   i_rx_empty;
  logic [DATA_BITS-1:0]   i_r_data;
  logic                   o_rd_uart;
  logic                   i_tx_full;
  logic [DATA_BITS-1:0]   o_w_data;
  logic                   o_wr_uart;
  logic [W-1:0]           o_op_a;
  logic [W-1:0]           o_op_b;
  logic [OPCODE_BITS-1:0] o_op_code;
  logic [W-1:0]           i_result;
  logic                   o_busy;

  modport master (
    input  i_rx_empty, i_r_data, i_tx_full, i_result,
    output o_rd_uart, o_w_data, o_wr_uart, o_op_a, o_op_b, o_op_code, o_busy
  );

  modport slave (
    output i_rx_empty, i_r_data, i_tx_full, i_result,
    input  o_rd_uart, o_w_data, o_wr_uart, o_op_a, o_op_b, o_op_code, o_busy
  );
endinterface

// File: rtl/uart_alu_pkt_ctrl.sv
// Packet controller between a UART (RX/TX FIFOs) and a combinational ALU.
// Receives SYNC, OPC, A (LSB first), B (LSB first), CHK; checks the XOR checksum and
// opcode range, runs the ALU for one cycle and replies with a status byte followed, on
// success, by the result (LSB first). Inter-byte silence inside a packet is bounded by
// TIMEOUT cycles.
// Ports:
//   i_clk   : clock, rising edge
//   i_reset : synchronous active-low reset
//   bus     : uart_alu_pkt_ctrl_if.master (FIFO handshakes, ALU operands/result, busy)
module uart_alu_pkt_ctrl #(
  parameter int unsigned          DATA_BITS   = 8,
  parameter int unsigned          OPCODE_BITS = 6,
  parameter int unsigned          OP_BYTES    = 2,
  parameter logic [DATA_BITS-1:0] SYNC_BYTE   = 8'hA5,
  parameter int unsigned          TIMEOUT     = 50000
) (
  input logic                  i_clk,
  input logic                  i_reset,
  uart_alu_pkt_ctrl_if.master  bus
);
  localparam int unsigned W  = OP_BYTES * DATA_BITS;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam int unsigned IW = (OP_BYTES > 1) ? $clog2(OP_BYTES) : 1;

  localparam logic [TW-1:0] TmoLimit = TW'(TIMEOUT);
  localparam logic [IW-1:0] LastIdx  = IW'(OP_BYTES - 1);

  localparam logic [DATA_BITS-1:0] StatOk    = DATA_BITS'(0);
  localparam logic [DATA_BITS-1:0] StatCsum  = DATA_BITS'(1);
  localparam logic [DATA_BITS-1:0] StatTmo   = DATA_BITS'(2);
  localparam logic [DATA_BITS-1:0] StatBadOp = DATA_BITS'(3);

  // Receive states occupy the low codes so "receiving" is a simple compare.
  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StOpc    = 3'd1;
  localparam logic [2:0] StOpa    = 3'd2;
  localparam logic [2:0] StOpb    = 3'd3;
  localparam logic [2:0] StChk    = 3'd4;
  localparam logic [2:0] StExec   = 3'd5;
  localparam logic [2:0] StTxStat = 3'd6;
  localparam logic [2:0] StTxRes  = 3'd7;

  logic [2:0]             state_q,   state_d;
  logic [W-1:0]           op_a_q,    op_a_d;
  logic [W-1:0]           op_b_q,    op_b_d;
  logic [OPCODE_BITS-1:0] op_code_q, op_code_d;
  logic                   bad_op_q,  bad_op_d;
  logic [DATA_BITS-1:0]   csum_q,    csum_d;
  logic [IW-1:0]          idx_q,     idx_d;
  logic [TW-1:0]          tmo_q,     tmo_d;
  logic [DATA_BITS-1:0]   status_q,  status_d;
  logic [W-1:0]           res_q,     res_d;

  logic                 rx_state, in_pkt, tx_state, tmo_hit, pop, push;
  logic [DATA_BITS-1:0] w_data;

  assign rx_state = (state_q <= StChk);
  assign in_pkt   = (state_q >= StOpc) && (state_q <= StChk);
  assign tx_state = (state_q == StTxStat) || (state_q == StTxRes);
  assign tmo_hit  = in_pkt && (tmo_q == TmoLimit);

  // Strobes are gated by reset so nothing is popped or pushed while reset is held.
  // A timeout takes priority over a byte that happens to arrive in the same cycle.
  assign pop  = i_reset && rx_state && !bus.i_rx_empty && !tmo_hit;
  assign push = i_reset && tx_state && !bus.i_tx_full;

  always_comb begin
    w_data = '0;
    if (i_reset) begin
      if (state_q == StTxStat)     w_data = status_q;
      else if (state_q == StTxRes) w_data = res_q[DATA_BITS-1:0];
    end
  end

  always_comb begin
    state_d   = state_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    op_code_d = op_code_q;
    bad_op_d  = bad_op_q;
    csum_d    = csum_q;
    idx_d     = idx_q;
    tmo_d     = tmo_q;
    status_d  = status_q;
    res_d     = res_q;

    // Silence counter: saturating, cleared by any pop (including SYNC, i.e. entry to OPC).
    if (in_pkt && bus.i_rx_empty && (tmo_q != TmoLimit)) tmo_d = tmo_q + 1'b1;
    if (pop) tmo_d = '0;

    case (state_q)
      StIdle: begin
        if (pop && (bus.i_r_data == SYNC_BYTE)) begin
          csum_d  = '0;
          state_d = StOpc;
        end
      end

      StOpc: begin
        if (tmo_hit) begin
          status_d = StatTmo;
          state_d  = StTxStat;
        end else if (pop) begin
          op_code_d = bus.i_r_data[OPCODE_BITS-1:0];
          bad_op_d  = |(bus.i_r_data >> OPCODE_BITS);
          csum_d    = csum_q ^ bus.i_r_data;
          idx_d     = '0;
          state_d   = StOpa;
        end
      end

      StOpa: begin
        if (tmo_hit) begin
          status_d = StatTmo;
          state_d  = StTxStat;
        end else if (pop) begin
          for (int unsigned k = 0; k < OP_BYTES; k++) begin
            if (idx_q == IW'(k)) op_a_d[k*DATA_BITS +: DATA_BITS] = bus.i_r_data;
          end
          csum_d = csum_q ^ bus.i_r_data;
          if (idx_q == LastIdx) begin
            idx_d   = '0;
            state_d = StOpb;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end

      StOpb: begin
        if (tmo_hit) begin
          status_d = StatTmo;
          state_d  = StTxStat;
        end else if (pop) begin
          for (int unsigned k = 0; k < OP_BYTES; k++) begin
            if (idx_q == IW'(k)) op_b_d[k*DATA_BITS +: DATA_BITS] = bus.i_r_data;
          end
          csum_d = csum_q ^ bus.i_r_data;
          if (idx_q == LastIdx) begin
            idx_d   = '0;
            state_d = StChk;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end

      StChk: begin
        if (tmo_hit) begin
          status_d = StatTmo;
          state_d  = StTxStat;
        end else if (pop) begin
          if (bus.i_r_data != csum_q) begin
            status_d = StatCsum;
            state_d  = StTxStat;
          end else if (bad_op_q) begin
            status_d = StatBadOp;
            state_d  = StTxStat;
          end else begin
            state_d = StExec;
          end
        end
      end

      StExec: begin
        res_d    = bus.i_result;
        status_d = StatOk;
        state_d  = StTxStat;
      end

      StTxStat: begin
        if (push) begin
          if (status_q == StatOk) begin
            idx_d   = '0;
            state_d = StTxRes;
          end else begin
            state_d = StIdle;
          end
        end
      end

      StTxRes: begin
        // Shift so the next byte to send is always in the low lane.
        if (push) begin
          res_d = res_q >> DATA_BITS;
          if (idx_q == LastIdx) begin
            idx_d   = '0;
            state_d = StIdle;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_q   <= StIdle;
      op_a_q    <= '0;
      op_b_q    <= '0;
      op_code_q <= '0;
      bad_op_q  <= 1'b0;
      csum_q    <= '0;
      idx_q     <= '0;
      tmo_q     <= '0;
      status_q  <= '0;
      res_q     <= '0;
    end else begin
      state_q   <= state_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      op_code_q <= op_code_d;
      bad_op_q  <= bad_op_d;
      csum_q    <= csum_d;
      idx_q     <= idx_d;
      tmo_q     <= tmo_d;
      status_q  <= status_d;
      res_q     <= res_d;
    end
  end

  assign bus.o_rd_uart = pop;
  assign bus.o_wr_uart = push;
  assign bus.o_w_data  = w_data;
  assign bus.o_op_a    = op_a_q;
  assign bus.o_op_b    = op_b_q;
  assign bus.o_op_code = op_code_q;
  assign bus.o_busy    = (state_q != StIdle);
endmodule

// File: doc/uart_alu_pkt_ctrl.md
UART_ALU_PKT_CTRL -- requirements
Module: uart_alu_pkt_ctrl

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8: UART byte width.
REQ-002 SHALL have parameter OPCODE_BITS, default 6: ALU opcode width (OPCODE_BITS <= DATA_BITS).
REQ-003 SHALL have parameter OP_BYTES, default 2: bytes per operand and result; W = OP_BYTES*DATA_BITS.
REQ-004 SHALL have parameter SYNC_BYTE, default 8'hA5: packet start marker.
REQ-005 SHALL have parameter TIMEOUT, default 50000: maximum idle cycles allowed between bytes inside a packet.
REQ-006 SHALL have port i_clk, input, 1: single clock; all logic rising-edge.
REQ-007 SHALL have port i_reset, input, 1: synchronous, active-low reset.
REQ-008 SHALL have port i_rx_empty, input, 1: receive FIFO empty.
REQ-009 SHALL have port i_r_data, input, DATA_BITS: receive FIFO head (first-word-fall-through).
REQ-010 SHALL have port o_rd_uart, output, 1: receive FIFO pop strobe.
REQ-011 SHALL have port i_tx_full, input, 1: transmit FIFO full.
REQ-012 SHALL have port o_w_data, output, DATA_BITS: byte to transmit.
REQ-013 SHALL have port o_wr_uart, output, 1: transmit FIFO push strobe.
REQ-014 SHALL have ports o_op_a and o_op_b, output, W each: ALU operands.
REQ-015 SHALL have port o_op_code, output, OPCODE_BITS: ALU opcode.
REQ-016 SHALL have port i_result, input, W: combinational ALU result.
REQ-017 SHALL have port o_busy, output, 1: high in every state except IDLE.

Function
REQ-018 Packet format SHALL be: SYNC, OPC, A (OP_BYTES, LSB first), B (OP_BYTES, LSB first), CHK, where CHK = XOR of the OPC, A and B bytes.
REQ-019 The FSM SHALL have states IDLE, OPC, OPA, OPB, CHK, EXEC, TX_STAT, TX_RES.
REQ-020 In a receive state (IDLE..CHK), the block SHALL pulse o_rd_uart for one cycle only when i_rx_empty=0, sampling i_r_data in that same cycle; it SHALL pop at most one byte per cycle.
REQ-021 In IDLE, a popped byte other than SYNC_BYTE SHALL be discarded; SYNC_BYTE SHALL move the FSM to OPC.
REQ-022 The block SHALL clear a byte index on entry to OPA and OPB, and SHALL advance to the next state after OP_BYTES pops.
REQ-023 OPC SHALL load o_op_code from the low OPCODE_BITS bits and set a bad-opcode flag if any upper bit is 1.
REQ-024 o_op_a, o_op_b and o_op_code SHALL be registered, updated only while their bytes are being received, and otherwise held.
REQ-025 A running XOR SHALL be cleared at SYNC; at CHK the received byte SHALL be compared against it.
REQ-026 On CHK, the status SHALL be set as follows, in priority order: mismatch -> 0x01 (to TX_STAT); bad opcode -> 0x03 (to TX_STAT); otherwise -> EXEC.
REQ-027 EXEC SHALL last exactly one cycle, register i_result, set status 0x00, and go to TX_STAT.
REQ-028 In TX_STAT and TX_RES, the block SHALL pulse o_wr_uart for one cycle only when i_tx_full=0, with o_w_data valid in that same cycle.
REQ-029 TX_STAT SHALL send the status byte; the next state SHALL be TX_RES if status is 0x00, otherwise IDLE.
REQ-030 TX_RES SHALL send the registered result LSB byte first, one byte per accepted write, and return to IDLE after OP_BYTES bytes.
REQ-031 While i_tx_full=1, the block SHALL stall without dropping or duplicating any byte.
REQ-032 A timeout counter SHALL be cleared on every pop and on entry to OPC, and SHALL increment each cycle in OPC..CHK while i_rx_empty=1.
REQ-033 When the timeout counter reaches TIMEOUT, the block SHALL set status 0x02 and go to TX_STAT; no pop SHALL occur that cycle.
REQ-034 The timeout counter SHALL be sized $clog2(TIMEOUT+1) and SHALL saturate rather than wrap.
REQ-035 o_rd_uart and o_wr_uart SHALL never be high in the same cycle.

Reset
REQ-036 With i_reset=0 at a clock edge, the block SHALL set state=IDLE, all outputs 0, counters, checksum, flags and the result register 0, regardless of the current state; a packet in flight is abandoned and none of its bytes are sent.

Verification
REQ-037 A5 20 34 12 01 00 07, ALU model = add -> o_op_a=0x1234, o_op_b=0x0001; TX 00 35 12; o_busy low afterwards.
REQ-038 A5 20 34 12 01 00 08 -> TX 01 only; EXEC never entered; next valid packet processed normally.
REQ-039 A5 C0 00 00 00 00 C0 -> TX 03 only.
REQ-040 A5 20 then silence for TIMEOUT cycles -> TX 02 only; return to IDLE; following bytes 00 FF discarded.
REQ-041 Bytes 00 FF before a valid packet, with i_tx_full held high for 20 cycles during the response -> bytes 00 FF discarded; response 00 35 12 delivered intact, in order, each byte once.
REQ-042 i_reset=0 asserted during OPB, then the valid packet from REQ-037 -> no TX from the aborted packet; outputs 0 after reset; response 00 35 12 for the new packet.
